// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The requester drives start and the operands; the adder returns busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, built around a two-half-adder full-adder slice.
// A start/busy/done handshake loads the operands and returns a registered sum and carry-out.
module myHalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] ra_r;
  logic [WIDTH-1:0] rb_r;
  logic [WIDTH-1:0] ws_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;

  logic             s1_s;
  logic             c1_s;
  logic             s_s;
  logic             c2_s;
  logic             c_s;
  logic             last_s;
  logic [WIDTH-1:0] ws_next_s;

  // Full-adder slice: first half adder combines the operand bits, second folds in the carry.
  myHalfAdder u_ha0 (.a(ra_r[0]), .b(rb_r[0]), .s(s1_s), .c(c1_s));
  myHalfAdder u_ha1 (.a(s1_s),    .b(carry_r), .s(s_s),  .c(c2_s));
  assign c_s = c1_s | c2_s;

  assign last_s    = (cnt_r == CW'(WIDTH - 1));
  assign ws_next_s = {s_s, ws_r[WIDTH-1:1]};

  assign bus.busy = (state_r == RUN);
  assign bus.done = (state_r == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; an unused encoding falls back to IDLE
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Working registers and result; sum/cout only change on the terminal bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_r    <= '0;
      rb_r    <= '0;
      ws_r    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            ra_r    <= bus.a;
            rb_r    <= bus.b;
            carry_r <= bus.cin;
            ws_r    <= '0;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          ra_r    <= {1'b0, ra_r[WIDTH-1:1]};
          rb_r    <= {1'b0, rb_r[WIDTH-1:1]};
          ws_r    <= ws_next_s;
          carry_r <= c_s;
          cnt_r   <= cnt_r + 1'b1;
          if (last_s) begin
            sum_r  <= ws_next_s;
            cout_r <= c_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: stimulus pushes expected {cout,sum} into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errs = 0;
  int   done_cnt = 0;
  logic [W:0] exp_q[$];

  serial_adder_if #(.WIDTH(W)) ifc ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ifc.done === 1'b1) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_done: got {cout,sum}=0x%0h expected no done", {ifc.cout, ifc.sum});
        end else begin
          e = exp_q.pop_front();
          if ({ifc.cout, ifc.sum} !== e) begin
            errs++;
            $display("FAIL result: got {cout,sum}=0x%0h expected 0x%0h", {ifc.cout, ifc.sum}, e);
          end
        end
      end
    end
  end

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (ifc.busy === 1'b1) bcnt++;
      if (ifc.done === 1'b1) break;
    end
  endtask

  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input string name);
    int lat;
    int bcnt;
    logic [W:0] sum_w;
    @(posedge clk);
    #1;
    ifc.a = ta; ifc.b = tb; ifc.cin = tc; ifc.start = 1'b1;
    sum_w = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    exp_q.push_back(sum_w);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_done(lat, bcnt);
    check({name, "_latency"}, lat, W + 1);
    check({name, "_busy_cycles"}, bcnt, W);
  endtask

  initial begin
    int d0;
    int n;
    int nd;
    int lows;
    int t[3];
    int lat;
    int bcnt;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", ifc.busy, 1'b0);
      check("idle_done", ifc.done, 1'b0);
      check("idle_sum", ifc.sum, 8'h00);
      check("idle_cout", ifc.cout, 1'b0);
    end

    do_add(8'h3C, 8'h42, 1'b0, "basic");
    repeat (3) @(negedge clk);
    check("hold_sum", ifc.sum, 8'h7E);
    check("hold_cout", ifc.cout, 1'b0);
    check("hold_done", ifc.done, 1'b0);

    do_add(8'hFF, 8'h01, 1'b0, "carry_ff01");
    do_add(8'hA5, 8'h5A, 1'b1, "carry_a55a");

    // Start re-pulsed during RUN with different operands must be ignored
    d0 = done_cnt;
    @(posedge clk);
    #1;
    ifc.a = 8'h10; ifc.b = 8'h01; ifc.cin = 1'b0; ifc.start = 1'b1;
    exp_q.push_back(9'h011);
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    wait_done(lat, bcnt);
    check("ignore_latency", lat, W - 2);
    repeat (12) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 1);
    check("ignore_sum_hold", ifc.sum, 8'h11);

    // Asynchronous reset in the middle of a run
    d0 = done_cnt;
    @(posedge clk);
    #1;
    ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.cin = 1'b0; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_done", ifc.done, 1'b0);
    check("rst_sum", ifc.sum, 8'h00);
    check("rst_cout", ifc.cout, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    do_add(8'h01, 8'h02, 1'b0, "after_rst");

    // Start held high: back-to-back operations
    repeat (3) exp_q.push_back(9'h100);
    @(posedge clk);
    #1;
    ifc.a = 8'h80; ifc.b = 8'h80; ifc.cin = 1'b0; ifc.start = 1'b1;
    n = 0; nd = 0; lows = 0;
    while (nd < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (ifc.done === 1'b1) begin
        t[nd] = n;
        nd++;
      end
      if (nd >= 1 && nd < 3 && ifc.busy === 1'b0) lows++;
    end
    ifc.start = 1'b0;
    check("b2b_done_count", nd, 3);
    check("b2b_period1", t[1] - t[0], W + 2);
    check("b2b_period2", t[2] - t[1], W + 2);
    check("b2b_busy_low", lows, 4);

    repeat (14) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder that sits directly downstream of the lab's half-adder stage. Its per-bit datapath is a full-adder slice built from two myHalfAdder instances plus an OR gate for carry-out. A carry flip-flop and shift registers process one bit per clock, LSB first. A start/busy/done handshake loads operands and returns a registered sum and carry-out.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on the start-sampling edge
b  input  WIDTH  operand B, captured on the start-sampling edge
cin  input  1  carry-in, captured on the start-sampling edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout are valid from this cycle
sum  output  WIDTH  registered result; holds its value until the next completion
cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-RUN):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Working shift registers, carry flop and bit counter all cleared.
- States:
  - IDLE: start=1 at an edge loads working regs ra<=a, rb<=b, carry<=cin, cnt<=0, and goes to RUN. start=0 stays in IDLE.
  - RUN: at each edge:
    - s = ra[0]^rb[0]^carry and c = majority(ra[0], rb[0], carry), both from the two-half-adder slice.
    - ra and rb shift right by 1; s shifts into the MSB of working sum reg ws; carry<=c; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: sum<=final ws, cout<=c, done<=1, go to DONE.
  - DONE: one cycle only. done returns to 0 and the block goes to IDLE on the next edge.
- Latency: start sampled at edge E0, done high in the cycle after edge E0+WIDTH, returns low after E0+WIDTH+1. Earliest next accept is edge E0+WIDTH+2 (for WIDTH=8, throughput is 1 add per 10 cycles).
- busy=1 exactly in RUN (WIDTH cycles); 0 in IDLE and DONE.
- start is ignored in RUN and DONE; a, b and cin may change freely after capture without affecting the operation in flight.
- start held high continuously starts back-to-back operations, one per WIDTH+2 cycles.
- sum/cout are never partially updated; during RUN they keep the previous result.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no overflow flag.
- cnt width = clog2(WIDTH); it must not wrap before the terminal count.
- No X on outputs after reset; an illegal state encoding recovers to IDLE.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high, start=0 for 5 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
- Basic add: WIDTH=8, a=0x3C, b=0x42, cin=0, start pulsed 1 cycle -> busy high 8 cycles, done pulses once 8 edges after the start edge, sum=0x7E, cout=0; sum stays 0x7E afterwards.
- Carry propagation: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Start ignored while busy: start a=0x10, b=0x01; re-pulse start with a=0xFF, b=0xFF on the 3rd RUN cycle -> result sum=0x11, cout=0; exactly one done pulse.
- Reset mid-operation: start a=0xFF, b=0xFF; drive rst_n low on the 4th RUN cycle, asynchronously between edges -> busy, done, sum and cout drop to 0 immediately; no done pulse after release; the next start a=0x01, b=0x02 gives sum=0x03.
- Back-to-back: start held high with a=0x80, b=0x80, cin=0 -> done every 10 cycles, each time sum=0x00, cout=1, busy low for exactly 2 cycles between runs.
